divider_controller: RTL and testbench

Sequencing controller for one 16-bit divider counter stage. It accepts a target/repeat configuration over a valid/ready handshake and drives the counter's `count_enable`, `count_reset` and `count_target` inputs. It watches `count_completed`, re-arms the counter after each completion, and emits one divider pulse per period for a programmed number of periods or continuously. It sits between the host/config logic and the counter, and the counter's `count_in` is tied to `sys_clk`.

---
 rtl/divider_controller_if.sv | 40 ++++
 rtl/divider_controller.sv | 104 ++++++++++
 tb/tb_divider_controller.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/divider_controller_if.sv
// divider_controller_if: host/config and counter-side signals of the divider controller
// Ports (signals):
//    cfg_valid/cfg_ready/cfg_target/cfg_repeats/cfg_error : configuration handshake
//    run_start/run_stop/run_hold/run_busy/run_done        : run control and status
//    ctr_enable/ctr_reset/ctr_target/ctr_completed        : 16-bit counter stage hookup
//    div_pulse/period_count                               : divider output and progress
// Modports: master = host + counter side, slave = controller.
interface divider_controller_if #(
   parameter int WIDTH        = 16,
   parameter int REPEAT_WIDTH = 8
);
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [WIDTH-1:0]        cfg_target;
   logic [REPEAT_WIDTH-1:0] cfg_repeats;
   logic                    cfg_error;
   logic                    run_start;
   logic                    run_stop;
   logic                    run_hold;
   logic                    ctr_enable;
   logic                    ctr_reset;
   logic [WIDTH-1:0]        ctr_target;
   logic                    ctr_completed;
   logic                    div_pulse;
   logic                    run_busy;
   logic                    run_done;
   logic [REPEAT_WIDTH-1:0] period_count;

   modport master (
      output cfg_valid, cfg_target, cfg_repeats, run_start, run_stop, run_hold, ctr_completed,
      input  cfg_ready, cfg_error, ctr_enable, ctr_reset, ctr_target, div_pulse, run_busy,
             run_done, period_count
   );

   modport slave (
      input  cfg_valid, cfg_target, cfg_repeats, run_start, run_stop, run_hold, ctr_completed,
      output cfg_ready, cfg_error, ctr_enable, ctr_reset, ctr_target, div_pulse, run_busy,
             run_done, period_count
   );
endinterface

// File: rtl/divider_controller.sv
// divider_controller: sequences one 16-bit counter stage to emit a divider pulse per period
// Ports:
//    sys_clk_i     : clock, rising edge
//    sys_reset_n_i : asynchronous active-low reset
//    bus           : divider_controller_if.slave (config handshake, run control, counter hookup)
module divider_controller #(
   parameter int WIDTH        = 16,
   parameter int REPEAT_WIDTH = 8
) (
   input logic                 sys_clk_i,
   input logic                 sys_reset_n_i,
   divider_controller_if.slave bus
);
   typedef enum logic {IDLE, COUNT} state_t;

   state_t                  state_q, state_d;
   logic [WIDTH-1:0]        tgt_q, tgt_d;
   logic [REPEAT_WIDTH-1:0] rep_q, rep_d;
   logic [REPEAT_WIDTH-1:0] pc_q, pc_d;
   logic                    loaded_q, loaded_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    ready, busy, en, clr, pulse;
   logic                    wrap;

   // stop beats a simultaneous completion
   assign wrap = bus.ctr_completed & ~bus.run_stop;

   always_ff @(posedge sys_clk_i or negedge sys_reset_n_i) begin
      if (!sys_reset_n_i) begin
         state_q  <= IDLE;
         tgt_q    <= '0;
         rep_q    <= '0;
         pc_q     <= '0;
         loaded_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         rep_q    <= rep_d;
         pc_q     <= pc_d;
         loaded_q <= loaded_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tgt_d    = tgt_q;
      rep_d    = rep_q;
      pc_d     = pc_q;
      loaded_d = loaded_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      ready    = 1'b0;
      busy     = 1'b0;
      en       = 1'b0;
      clr      = 1'b1;
      pulse    = 1'b0;
      if (state_q == IDLE) begin
         ready = 1'b1;
         // a config accepted alongside run_start applies to that run, so the start test uses loaded_d
         if (bus.cfg_valid) begin
            if (bus.cfg_target != '0) begin
               tgt_d    = bus.cfg_target;
               rep_d    = bus.cfg_repeats;
               loaded_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
         if (bus.run_start && loaded_d) begin
            state_d = COUNT;
            pc_d    = '0;
         end
      end else begin
         busy  = 1'b1;
         en    = ~bus.run_hold;
         clr   = wrap;
         pulse = wrap;
         if (bus.run_stop) begin
            state_d = IDLE;
         end else if (wrap) begin
            pc_d = pc_q + 1'b1;
            if (rep_q != '0 && pc_d == rep_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
      end
   end

   assign bus.cfg_ready    = ready;
   assign bus.cfg_error    = err_q;
   assign bus.ctr_enable   = en;
   assign bus.ctr_reset    = clr;
   assign bus.ctr_target   = tgt_q;
   assign bus.div_pulse    = pulse;
   assign bus.run_busy     = busy;
   assign bus.run_done     = done_q;
   assign bus.period_count = pc_q;
endmodule

// File: tb/tb_divider_controller.sv
// tb_divider_controller: directed checks of divider_controller against a behavioural counter
module tb_divider_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [15:0] cnt = '0;
   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   int done_at;
   int pulses[$];

   divider_controller_if #(.WIDTH(16), .REPEAT_WIDTH(8)) bus ();

   divider_controller #(.WIDTH(16), .REPEAT_WIDTH(8)) dut (
      .sys_clk_i     (clk),
      .sys_reset_n_i (rst_n),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   // behavioural counter stage: count_in tied to the clock, completion when count reaches target
   always_ff @(posedge clk) begin
      if (bus.ctr_reset) cnt <= '0;
      else if (bus.ctr_enable) cnt <= cnt + 16'd1;
   end
   assign bus.ctr_completed = (cnt == bus.ctr_target);

   typedef struct {
      logic [15:0] t;
      logic [7:0]  r;
      int          first;
      int          per;
      int          done;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // sample the current cycle, then advance to the next sampling point
   task automatic step();
      #1;
      if (bus.div_pulse) pulses.push_back(cyc);
      if (bus.run_done) done_at = cyc;
      @(negedge clk);
      cyc++;
   endtask

   task automatic cfg(input logic [15:0] t, input logic [7:0] r);
      bus.cfg_valid   = 1'b1;
      bus.cfg_target  = t;
      bus.cfg_repeats = r;
      #1;
      chk("cfg_ready_offer", bus.cfg_ready, 1);
      @(negedge clk);
      bus.cfg_valid = 1'b0;
   endtask

   task automatic start();
      bus.run_start = 1'b1;
      cyc = 0;
      done_at = -1;
      pulses.delete();
      step();
      bus.run_start = 1'b0;
   endtask

   initial begin
      bus.cfg_valid   = 1'b0;
      bus.cfg_target  = '0;
      bus.cfg_repeats = '0;
      bus.run_start   = 1'b0;
      bus.run_stop    = 1'b0;
      bus.run_hold    = 1'b0;
      vecs[0] = '{t: 16'd4, r: 8'd3, first: 5, per: 5, done: 16};
      vecs[1] = '{t: 16'd1, r: 8'd2, first: 2, per: 2, done: 5};
      vecs[2] = '{t: 16'd2, r: 8'd1, first: 3, per: 3, done: 4};
      vecs[3] = '{t: 16'd5, r: 8'd2, first: 6, per: 6, done: 13};
      #12;
      chk("rst_cfg_ready", bus.cfg_ready, 1);
      chk("rst_ctr_reset", bus.ctr_reset, 1);
      chk("rst_ctr_enable", bus.ctr_enable, 0);
      chk("rst_ctr_target", bus.ctr_target, 0);
      chk("rst_period_count", bus.period_count, 0);
      chk("rst_flags", {bus.div_pulse, bus.run_busy, bus.run_done, bus.cfg_error}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // illegal zero target: handshake completes, error pulses once, start stays ignored
      cfg(16'd0, 8'd5);
      #1;
      chk("err_pulse", bus.cfg_error, 1);
      @(negedge clk);
      #1;
      chk("err_once", bus.cfg_error, 0);
      chk("err_target_kept", bus.ctr_target, 0);
      @(negedge clk);
      start();
      step();
      step();
      #1;
      chk("start_unloaded_ignored", bus.run_busy, 0);
      @(negedge clk);

      // finite runs
      for (int i = 0; i < 4; i++) begin
         cfg(vecs[i].t, vecs[i].r);
         start();
         #1;
         chk("busy_first_cycle", bus.run_busy, 1);
         chk("ready_low_count", bus.cfg_ready, 0);
         while (done_at < 0 && cyc < 200) step();
         chk("run_timeout", (done_at < 0), 0);
         chk("pulse_total", pulses.size(), vecs[i].r);
         for (int k = 0; k < pulses.size(); k++)
            chk("pulse_cycle", pulses[k], vecs[i].first + k * vecs[i].per);
         chk("done_cycle", done_at, vecs[i].done);
         #1;
         chk("done_once", bus.run_done, 0);
         chk("final_count", bus.period_count, vecs[i].r);
         chk("ready_after", bus.cfg_ready, 1);
         chk("busy_after", bus.run_busy, 0);
         @(negedge clk);
      end

      // continuous run with hold in the second period, then stop on a completion
      cfg(16'd3, 8'd0);
      start();
      while (cyc < 6) step();
      bus.run_hold = 1'b1;
      step();
      step();
      bus.run_hold = 1'b0;
      while (cyc < 22) step();
      chk("hold_pulses", pulses.size(), 4);
      if (pulses.size() == 4) begin
         chk("hold_p0", pulses[0], 4);
         chk("hold_p1", pulses[1], 10);
         chk("hold_p2", pulses[2], 14);
         chk("hold_p3", pulses[3], 18);
      end
      bus.run_stop = 1'b1;
      #1;
      chk("stop_completed", bus.ctr_completed, 1);
      chk("stop_no_pulse", bus.div_pulse, 0);
      chk("stop_no_reset", bus.ctr_reset, 0);
      step();
      bus.run_stop = 1'b0;
      #1;
      chk("stop_idle", bus.run_busy, 0);
      chk("stop_count_kept", bus.period_count, 4);
      chk("stop_no_done", bus.run_done, 0);
      @(negedge clk);

      // period_count wraps modulo 256 in a long continuous run
      cfg(16'd1, 8'd0);
      start();
      while (cyc < 601) step();
      bus.run_stop = 1'b1;
      step();
      bus.run_stop = 1'b0;
      chk("wrap_pulses", pulses.size(), 300);
      #1;
      chk("wrap_count", bus.period_count, 44);
      @(negedge clk);

      // config and start in the same cycle: new target applies to that run
      cfg(16'd9, 8'd0);
      bus.cfg_valid   = 1'b1;
      bus.cfg_target  = 16'd2;
      bus.cfg_repeats = 8'd0;
      start();
      bus.cfg_valid = 1'b0;
      while (cyc < 4) step();
      chk("same_cycle_first", (pulses.size() > 0) ? pulses[0] : -1, 3);
      chk("same_cycle_target", bus.ctr_target, 2);
      bus.cfg_valid  = 1'b1;
      bus.cfg_target = 16'd7;
      #1;
      chk("count_ready_low", bus.cfg_ready, 0);
      step();
      bus.cfg_valid = 1'b0;
      #1;
      chk("count_no_accept", bus.ctr_target, 2);

      // asynchronous reset mid-run
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", bus.run_busy, 0);
      chk("mid_rst_ready", bus.cfg_ready, 1);
      chk("mid_rst_ctr", {bus.ctr_reset, bus.ctr_enable, bus.div_pulse}, 3'b100);
      chk("mid_rst_target", bus.ctr_target, 0);
      chk("mid_rst_count", bus.period_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start();
      step();
      #1;
      chk("post_rst_start_ignored", bus.run_busy, 0);
      @(negedge clk);
      cfg(16'd2, 8'd1);
      start();
      while (done_at < 0 && cyc < 50) step();
      chk("post_rst_done", done_at, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
